// File: rtl/vgg_fp_pkg.sv
// ---------------------------------------------------------------------------
// vgg_fp_pkg
// Purpose : shared FP32 field layout constants and helpers used by the VGG16
//           datapath blocks (max-pooling, multiply, addition).
// Contents: FP_* bit-position constants, FP_POS_ZERO, fp32_t field view,
//           fp_mag() helper returning the unsigned {exp,mant} magnitude.
// ---------------------------------------------------------------------------
package vgg_fp_pkg;

   localparam int FP_WIDTH    = 32;
   localparam int FP_SIGN_BIT = 31;
   localparam int FP_EXP_MSB  = 30;
   localparam int FP_EXP_LSB  = 23;
   localparam int FP_MANT_MSB = 22;

   localparam logic [FP_WIDTH-1:0] FP_POS_ZERO = 32'h0000_0000;

   typedef struct packed {
      logic                        sign;
      logic [FP_EXP_MSB-FP_EXP_LSB:0] exp;
      logic [FP_MANT_MSB:0]        mant;
   } fp32_t;

   // {exp,mant} read as an unsigned integer orders FP32 magnitudes correctly
   function automatic logic [FP_EXP_MSB:0] fp_mag(input logic [FP_WIDTH-1:0] x);
      return x[FP_EXP_MSB:0];
   endfunction

endpackage

// File: rtl/fp_max2.sv
// ---------------------------------------------------------------------------
// fp_max2
// Purpose : combinational maximum of two FP32 values using sign-magnitude
//           ordering. Ties (including +0 vs -0) return operand a.
// Ports   : a - first operand (earlier pixel / buffered value)
//           b - second operand
//           y - max(a, b)
// ---------------------------------------------------------------------------
module fp_max2
   import vgg_fp_pkg::*;
(
   input  logic [FP_WIDTH-1:0] a,
   input  logic [FP_WIDTH-1:0] b,
   output logic [FP_WIDTH-1:0] y
);

   fp32_t                 fa;
   fp32_t                 fb;
   logic [FP_EXP_MSB:0]   mag_a;
   logic [FP_EXP_MSB:0]   mag_b;

   assign fa    = a;
   assign fb    = b;
   assign mag_a = fp_mag(a);
   assign mag_b = fp_mag(b);

   // Both zeros compare equal regardless of sign, so that case is caught
   // before the mixed-sign rule would otherwise prefer +0.
   // Same-sign operands: larger magnitude wins when positive, smaller when
   // negative; b only wins on a strict inequality so ties keep a.
   always_comb begin
      y = a;
      if (mag_a == '0 && mag_b == '0) begin
         y = a;
      end else if (fa.sign != fb.sign) begin
         y = fa.sign ? b : a;
      end else if (!fa.sign) begin
         y = (mag_b > mag_a) ? b : a;
      end else begin
         y = (mag_b < mag_a) ? b : a;
      end
   end

endmodule

// File: rtl/maxpool2x2_fp.sv
// ---------------------------------------------------------------------------
// maxpool2x2_fp
// Purpose : 2x2 stride-2 max pooling over an FP32 raster stream from the 3x3
//           conv stage. One pooled pixel is emitted per non-overlapping 2x2
//           window, in raster order of the pooled map.
// Ports   : clk     - clock, rising edge
//           rst_n   - synchronous reset, ACTIVE-HIGH despite the name
//           i_valid - i_data carries a pixel this cycle (gaps allowed)
//           i_data  - input pixel, FP32
//           o_data  - pooled maximum, 0 whenever o_valid is low
//           o_valid - one-cycle pulse per pooled pixel
// ---------------------------------------------------------------------------
module maxpool2x2_fp
   import vgg_fp_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int IMAGE_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid
);

   localparam int HALF = IMAGE_WIDTH / 2;
   localparam int CW   = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [CW-1:0] LAST_IDX = CW'(IMAGE_WIDTH - 1);

   // Pooling windows must tile the map exactly and the comparator is FP32 only
   generate
      if ((IMAGE_WIDTH % 2) != 0 || IMAGE_WIDTH < 2) begin : g_bad_width
         $error("maxpool2x2_fp: IMAGE_WIDTH must be even and >= 2");
      end
      if (DATA_WIDTH != FP_WIDTH) begin : g_bad_data_width
         $error("maxpool2x2_fp: DATA_WIDTH must be 32 (FP32)");
      end
   endgenerate

   logic [CW-1:0]         col_cnt;
   logic [CW-1:0]         row_cnt;
   logic [FP_WIDTH-1:0]   pair_reg;
   logic [FP_WIDTH-1:0]   line_buf [HALF];
   logic [HW-1:0]         lb_idx;
   logic [FP_WIDTH-1:0]   h_max;
   logic [FP_WIDTH-1:0]   v_max;
   logic                  col_odd;
   logic                  row_odd;

   assign col_odd = col_cnt[0];
   assign row_odd = row_cnt[0];
   assign lb_idx  = HW'(col_cnt >> 1);

   // Horizontal max: left pixel held in pair_reg, right pixel arriving now
   fp_max2 u_h_max (
      .a (pair_reg),
      .b (i_data),
      .y (h_max)
   );

   // Vertical max: top-row pair maximum from the line buffer against the
   // bottom-row pair maximum being formed this cycle
   fp_max2 u_v_max (
      .a (line_buf[lb_idx]),
      .b (h_max),
      .y (v_max)
   );

   // Raster position, left-pixel capture and output register. The output
   // register clears every cycle so o_data/o_valid are single-cycle pulses;
   // a bottom-right pixel accept loads them for exactly the next cycle.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         col_cnt  <= '0;
         row_cnt  <= '0;
         pair_reg <= FP_POS_ZERO;
         o_valid  <= 1'b0;
         o_data   <= FP_POS_ZERO;
      end else begin
         o_valid <= 1'b0;
         o_data  <= FP_POS_ZERO;
         if (i_valid) begin
            if (!col_odd) begin
               pair_reg <= i_data;
            end else if (row_odd) begin
               o_valid <= 1'b1;
               o_data  <= v_max;
            end
            if (col_cnt == LAST_IDX) begin
               col_cnt <= '0;
               row_cnt <= (row_cnt == LAST_IDX) ? '0 : row_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
         end
      end
   end

   // Top-row pair maxima are parked here until the odd row below reads them.
   // No reset: every entry is rewritten on an even row before being read.
   always_ff @(posedge clk) begin
      if (!rst_n && i_valid && col_odd && !row_odd) begin
         line_buf[lb_idx] <= h_max;
      end
   end

endmodule

// File: tb/tb_maxpool2x2_fp.sv
// ---------------------------------------------------------------------------
// tb_maxpool2x2_fp
// Self-checking bench for maxpool2x2_fp (4x4 maps, FP32).
// ---------------------------------------------------------------------------
module tb_maxpool2x2_fp;

   localparam int W  = 4;
   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          i_valid;
   logic [DW-1:0] i_data;
   logic [DW-1:0] o_data;
   logic          o_valid;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;

   logic [DW-1:0] pos_frame [16];
   logic [DW-1:0] pulse_q [$];
   logic [DW-1:0] lit_q   [$];

   // Reference model state: the whole frame as seen so far, by raster index
   logic [DW-1:0] frame_mem [W*W];
   int            model_idx = 0;
   logic          exp_valid = 1'b0;
   logic [DW-1:0] exp_data  = '0;

   maxpool2x2_fp #(
      .DATA_WIDTH  (DW),
      .IMAGE_WIDTH (W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (i_valid),
      .i_data  (i_data),
      .o_data  (o_data),
      .o_valid (o_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Map an FP32 pattern onto a signed integer whose ordering is the
   // sign-magnitude ordering; +0 and -0 both map to 0.
   function automatic longint fpKey(input logic [DW-1:0] x);
      longint m;
      m = longint'(x[30:0]);
      return x[31] ? -m : m;
   endfunction

   // Window maximum scanning in raster order; only a strictly larger key
   // displaces the current best, so equal values keep the earliest pixel.
   function automatic logic [DW-1:0] windowMax(input logic [DW-1:0] p0, input logic [DW-1:0] p1,
                                               input logic [DW-1:0] p2, input logic [DW-1:0] p3);
      logic [DW-1:0] best;
      best = p0;
      if (fpKey(p1) > fpKey(best)) best = p1;
      if (fpKey(p2) > fpKey(best)) best = p2;
      if (fpKey(p3) > fpKey(best)) best = p3;
      return best;
   endfunction

   // Model: store each accepted pixel by frame position; when a window's
   // bottom-right pixel lands, the expected pulse is visible the next cycle.
   always @(posedge clk) begin
      int r;
      int c;
      if (rst_n) begin
         model_idx = 0;
         exp_valid = 1'b0;
         exp_data  = '0;
      end else begin
         exp_valid = 1'b0;
         exp_data  = '0;
         if (i_valid) begin
            frame_mem[model_idx] = i_data;
            r = model_idx / W;
            c = model_idx % W;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
               exp_valid = 1'b1;
               exp_data  = windowMax(frame_mem[(r-1)*W + c-1], frame_mem[(r-1)*W + c],
                                     frame_mem[r*W + c-1],     frame_mem[r*W + c]);
            end
            model_idx = (model_idx + 1) % (W*W);
         end
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle
   always @(negedge clk) begin
      if (cycle > 0) begin
         n_checks++;
         if (o_valid !== exp_valid || o_data !== exp_data) begin
            n_fail++;
            $display("[TB] FAIL cycle_compare cycle=%0d got valid=%b data=%h expected valid=%b data=%h",
                     cycle, o_valid, o_data, exp_valid, exp_data);
         end
         if (o_valid === 1'b1) pulse_q.push_back(o_data);
      end
   end

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(negedge clk);
         i_valid = 1'b0;
         i_data  = '0;
      end
   endtask

   // Drive one pixel; with gaps enabled, idle cycles are inserted at random
   task automatic applyStimulus(input logic [DW-1:0] d, input bit gaps);
      if (gaps) begin
         while ($urandom_range(0, 1) == 1) idleCycles(1);
      end
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = d;
   endtask

   task automatic checkOutput(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("[TB] FAIL %s got=%h expected=%h", name, got, want);
      end
   endtask

   // Compare the logged pulses against hand-computed literal values
   task automatic checkPulseLog(input string tag);
      checkOutput({tag, "_count"}, DW'(pulse_q.size()), DW'(lit_q.size()));
      for (int i = 0; i < lit_q.size() && i < pulse_q.size(); i++)
         checkOutput($sformatf("%s_pulse%0d", tag, i), pulse_q[i], lit_q[i]);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         shortint e;
         int      v;
         v = i + 1;
         e = 0;
         while ((v >> (e + 1)) != 0) e++;
         pos_frame[i] = {1'b0, 8'(127 + e), 23'((v - (1 << e)) << (23 - e))};
      end

      rst_n   = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;
      idleCycles(2);
      checkOutput("reset_o_valid", {31'd0, o_valid}, 32'd0);
      checkOutput("reset_o_data", o_data, 32'h0000_0000);
      checkOutput("model_pixel6", pos_frame[5], 32'h40C0_0000);
      rst_n = 1'b0;

      $display("[TB] positive frame, continuous");
      pulse_q.delete();
      for (int i = 0; i < 16; i++) applyStimulus(pos_frame[i], 1'b0);
      idleCycles(3);
      lit_q = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
      checkPulseLog("pos_frame");

      $display("[TB] negative frame, continuous");
      pulse_q.delete();
      for (int i = 0; i < 16; i++) applyStimulus(pos_frame[i] | 32'h8000_0000, 1'b0);
      idleCycles(3);
      lit_q = '{32'hBF80_0000, 32'hC040_0000, 32'hC110_0000, 32'hC130_0000};
      checkPulseLog("neg_frame");

      $display("[TB] mixed sign and zero windows");
      pulse_q.delete();
      begin
         logic [DW-1:0] mixed [16];
         mixed = '{32'h8000_0000, 32'h0000_0000, 32'hC2C8_0000, 32'h3A83_126F,
                   32'hBF80_0000, 32'hC000_0000, 32'hC000_0000, 32'hBF80_0000,
                   32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                   32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
         for (int i = 0; i < 16; i++) applyStimulus(mixed[i], 1'b0);
      end
      idleCycles(3);
      lit_q = '{32'h8000_0000, 32'h3A83_126F, 32'h40C0_0000, 32'h4100_0000};
      checkPulseLog("mixed_frame");

      $display("[TB] positive frame, random gaps");
      pulse_q.delete();
      for (int i = 0; i < 16; i++) applyStimulus(pos_frame[i], 1'b1);
      idleCycles(3);
      lit_q = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
      checkPulseLog("gap_frame");

      $display("[TB] back-to-back frames");
      pulse_q.delete();
      for (int i = 0; i < 16; i++) applyStimulus(pos_frame[i], 1'b0);
      for (int i = 0; i < 16; i++) applyStimulus(pos_frame[i] | 32'h8000_0000, 1'b0);
      idleCycles(3);
      lit_q = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000,
                32'hBF80_0000, 32'hC040_0000, 32'hC110_0000, 32'hC130_0000};
      checkPulseLog("b2b_frames");

      $display("[TB] reset mid-frame");
      for (int i = 0; i < 7; i++) applyStimulus(pos_frame[i], 1'b0);
      @(negedge clk);
      rst_n   = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;
      pulse_q.delete();
      @(negedge clk);
      checkOutput("midreset_o_valid", {31'd0, o_valid}, 32'd0);
      checkOutput("midreset_o_data", o_data, 32'h0000_0000);
      rst_n = 1'b0;
      for (int i = 0; i < 16; i++) applyStimulus(pos_frame[i], 1'b0);
      idleCycles(3);
      lit_q = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
      checkPulseLog("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
